// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: shared state encoding, mode codes and counter sizing for decoder_seq.
`default_nettype none

package decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2,
    SCAN  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Sized so the larger of the two limits fits, counting 0..limit-1.
  function automatic int cnt_width(input int pulse_len, input int scan_div);
    int m;
    m = (pulse_len > scan_div) ? pulse_len : scan_div;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_seq_onehot_dec.sv
// onehot_dec: combinational IN_W-bit select to 2**IN_W-bit one-hot decoder.
`default_nettype none

module onehot_dec #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]      sel,
  output logic [2**IN_W-1:0]   dec
);

  for (genvar i = 0; i < 2**IN_W; i++) begin : g_bit
    assign dec[i] = (sel == IN_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with valid/ready input and DIRECT/PULSE/SCAN output modes.
`default_nettype none

module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int PULSE_LEN = 4,
  parameter int SCAN_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      sel,
  output logic [2**IN_W-1:0]   out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int OUT_W = 2**IN_W;
  localparam int CNT_W = cnt_width(PULSE_LEN, SCAN_DIV);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] dec_out;
  logic             accept;

  onehot_dec #(.IN_W(IN_W)) u_dec (
    .sel (sel),
    .dec (dec_out)
  );

  assign in_ready  = en && (state != PULSE) && (mode != MODE_RSVD);
  assign accept    = in_valid && in_ready;
  assign out_valid = |out;
  assign busy      = (state == PULSE) || (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      cnt   <= '0;
    end else if (!en) begin
      state <= IDLE;
      out   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      // Every accept re-seeds from the decoder and restarts the counter.
      out <= dec_out;
      cnt <= '0;
      case (mode)
        MODE_PULSE: state <= PULSE;
        MODE_SCAN:  state <= SCAN;
        default:    state <= HOLD;
      endcase
    end else begin
      case (state)
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            state <= IDLE;
            out   <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            out <= {out[OUT_W-2:0], out[OUT_W-1]};
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed stimulus with a per-cycle expectation queue checked by a separate monitor.
`default_nettype none

module tb_decoder_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] out;
  logic       out_valid;
  logic       busy;

  int n_tests  = 0;
  int n_failed = 0;

  // Expectation: {out[3:0], busy, in_ready}
  logic [5:0] exp_q[$];

  decoder_seq #(.IN_W(2), .PULSE_LEN(4), .SCAN_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check_all(input string tag, input logic [3:0] xo, input logic xb, input logic xr,
                           input logic chk_rdy);
    n_tests++;
    if (out !== xo) begin
      n_failed++;
      $display("FAIL %s out: got %b expected %b @%0t", tag, out, xo, $time);
    end
    n_tests++;
    if (out_valid !== (|xo)) begin
      n_failed++;
      $display("FAIL %s out_valid: got %b expected %b @%0t", tag, out_valid, |xo, $time);
    end
    n_tests++;
    if (busy !== xb) begin
      n_failed++;
      $display("FAIL %s busy: got %b expected %b @%0t", tag, busy, xb, $time);
    end
    if (chk_rdy) begin
      n_tests++;
      if (in_ready !== xr) begin
        n_failed++;
        $display("FAIL %s in_ready: got %b expected %b @%0t", tag, in_ready, xr, $time);
      end
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      check_all("cycle", e[5:2], e[1], e[0], 1'b1);
    end
  end

  task automatic cyc(input logic e, input logic [1:0] m, input logic v, input logic [1:0] s,
                     input logic [3:0] xo, input logic xb, input logic xr);
    en       = e;
    mode     = m;
    in_valid = v;
    sel      = s;
    exp_q.push_back({xo, xb, xr});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 2'b00;
    in_valid = 1'b0;
    sel      = 2'b00;
    #2;
    check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset release and DIRECT hold
    cyc(1, 2'b00, 0, 2'd0, 4'b0000, 0, 1);
    cyc(1, 2'b00, 1, 2'd2, 4'b0000, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 2'b00, 0, 2'd0, 4'b0100, 0, 1);
    cyc(1, 2'b00, 1, 2'd3, 4'b0100, 0, 1);
    cyc(1, 2'b00, 0, 2'd0, 4'b1000, 0, 1);

    // PULSE of 4 cycles; in_valid held high is ignored
    cyc(1, 2'b01, 1, 2'd1, 4'b1000, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 2'b01, 1, 2'd1, 4'b0010, 1, 0);
    cyc(1, 2'b01, 0, 2'd1, 4'b0000, 0, 1);

    // SCAN with divider 2, then re-seed at sel=0 mid-scan
    cyc(1, 2'b10, 1, 2'd3, 4'b0000, 0, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b1000, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b1000, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0001, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0001, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0010, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0010, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0100, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0100, 1, 1);
    cyc(1, 2'b10, 1, 2'd0, 4'b1000, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0001, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0001, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0010, 1, 1);

    // Enable abort during PULSE cycle 2
    cyc(1, 2'b01, 1, 2'd2, 4'b0010, 1, 1);
    cyc(1, 2'b01, 0, 2'd0, 4'b0100, 1, 0);
    cyc(0, 2'b01, 0, 2'd0, 4'b0100, 1, 0);
    cyc(1, 2'b00, 0, 2'd0, 4'b0000, 0, 1);
    cyc(1, 2'b00, 1, 2'd1, 4'b0000, 0, 1);
    cyc(1, 2'b00, 0, 2'd0, 4'b0010, 0, 1);

    // Reserved mode: never accepted, output unchanged
    cyc(1, 2'b11, 1, 2'd3, 4'b0010, 0, 0);
    cyc(1, 2'b11, 1, 2'd3, 4'b0010, 0, 0);
    cyc(1, 2'b11, 1, 2'd3, 4'b0010, 0, 0);
    cyc(0, 2'b00, 0, 2'd0, 4'b0010, 0, 0);
    cyc(1, 2'b00, 0, 2'd0, 4'b0000, 0, 1);

    // Async reset mid-SCAN, then DIRECT accept
    cyc(1, 2'b10, 1, 2'd0, 4'b0000, 0, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0001, 1, 1);
    cyc(1, 2'b10, 0, 2'd0, 4'b0001, 1, 1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 2'b00, 1, 2'd2, 4'b0000, 0, 1);
    cyc(1, 2'b00, 0, 2'd0, 4'b0100, 0, 1);
    cyc(1, 2'b00, 0, 2'd0, 4'b0100, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

`default_nettype wire
